// File: rtl/uart_rx_if.sv
// Serial receive bundle: line input plus byte/strobe/status outputs.
// The receiver uses the slave view; the line driver uses the master view.
interface uart_rx_if;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_error;
    logic       rx_busy;

    modport master (
        output rxd,
        input  rx_data,
        input  rx_done,
        input  rx_error,
        input  rx_busy
    );

    modport slave (
        input  rxd,
        output rx_data,
        output rx_done,
        output rx_error,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, 3-sample majority vote per bit,
// optional even/odd parity, stop-bit check, one byte per rx_done pulse.
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int PARITY   = 0
) (
    input  logic      clk,
    input  logic      rstn,
    uart_rx_if.slave  bus
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [DW-1:0] r_div;
    logic [3:0]    r_scnt;
    logic          r_s0;
    logic          r_s1;
    logic [2:0]    r_bidx;
    logic [7:0]    r_shift;
    logic          r_par_err;
    logic [7:0]    r_data;
    logic          r_done;
    logic          r_err;

    logic w_fall;
    logic w_tick;
    logic w_vote_tick;
    logic w_end_tick;
    logic w_vote;
    logic w_par_mis;
    logic w_busy;
    logic w_shift_en;
    logic w_par_en;
    logic w_load;
    logic w_err_nxt;
    logic w_last_bit;

    // Synchronizer idles high so reset release never looks like a start edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= bus.rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall = r_prev & ~r_sync2;

    assign w_tick      = (r_state != S_IDLE) && (r_div == DIV_LAST);
    assign w_vote_tick = w_tick && (r_scnt == 4'd9);
    assign w_end_tick  = w_tick && (r_scnt == 4'd15);
    assign w_last_bit  = (r_bidx == 3'd7);

    assign w_vote = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
    assign w_par_mis = (^r_shift) ^ w_vote ^ ODD;

    // Divider parks at zero in IDLE so the bit phase tracks the start edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div <= '0;
        end else if (r_state == S_IDLE || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_scnt <= 4'd0;
        end else if (r_state == S_IDLE) begin
            r_scnt <= 4'd0;
        end else if (w_tick) begin
            r_scnt <= r_scnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else if (w_tick) begin
            if (r_scnt == 4'd7) r_s0 <= r_sync2;
            if (r_scnt == 4'd8) r_s1 <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_vote_tick && w_vote) begin
                    w_state_nxt = S_IDLE;
                end else if (w_end_tick) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_end_tick && w_last_bit) begin
                    w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (w_end_tick) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // Leave mid-stop-bit so an immediately following start is seen
                if (w_vote_tick) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = 1'b1;
        w_shift_en = 1'b0;
        w_par_en   = 1'b0;
        w_load     = 1'b0;
        w_err_nxt  = ~w_vote | r_par_err;
        unique case (r_state)
            S_IDLE:  w_busy     = 1'b0;
            S_START: w_busy     = 1'b1;
            S_DATA:  w_shift_en = w_vote_tick;
            S_PAR:   w_par_en   = w_vote_tick;
            S_STOP:  w_load     = w_vote_tick;
            default: w_busy     = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bidx <= 3'd0;
        end else if (r_state != S_DATA) begin
            r_bidx <= 3'd0;
        end else if (w_end_tick) begin
            r_bidx <= r_bidx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift <= 8'h00;
        end else if (w_shift_en) begin
            r_shift <= {w_vote, r_shift[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_par_err <= 1'b0;
        end else if (r_state == S_START) begin
            r_par_err <= 1'b0;
        end else if (w_par_en) begin
            r_par_err <= w_par_mis;
        end
    end

    // Byte and status are published even on error; strobes last one clk
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data <= 8'h00;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_load;
            r_err  <= w_load & w_err_nxt;
            if (w_load) r_data <= r_shift;
        end
    end

    assign bus.rx_data  = r_data;
    assign bus.rx_done  = r_done;
    assign bus.rx_error = r_err;
    assign bus.rx_busy  = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx, one DUT without parity
// and one with even parity, checked against a frame-level model.
module tb_uart_rx;

    localparam int CLK_FREQ = 6_400_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = 64;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if if0 ();
    uart_rx_if if1 ();

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .PARITY   (0)
    ) u_dut0 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if0)
    );

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .PARITY   (1)
    ) u_dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if1)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned done_cyc0 = 0;
    int viol0 = 0;
    int viol1 = 0;
    logic pd0 = 1'b0;
    logic pd1 = 1'b0;

    logic [8:0] obs0[$];
    logic [8:0] obs1[$];
    logic [8:0] exp0[$];
    logic [8:0] exp1[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (if0.rx_done === 1'b1) begin
            obs0.push_back({if0.rx_error, if0.rx_data});
            done_cyc0 <= cyc;
        end
        viol0 <= viol0
               + int'(if0.rx_error === 1'b1 && if0.rx_done !== 1'b1)
               + int'(if0.rx_done === 1'b1 && pd0 === 1'b1);
        pd0 <= if0.rx_done;
    end

    always @(negedge clk) begin
        if (if1.rx_done === 1'b1) begin
            obs1.push_back({if1.rx_error, if1.rx_data});
        end
        viol1 <= viol1
               + int'(if1.rx_error === 1'b1 && if1.rx_done !== 1'b1)
               + int'(if1.rx_done === 1'b1 && pd1 === 1'b1);
        pd1 <= if1.rx_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int ln, input logic v);
        if (ln == 0) if0.rxd = v;
        else         if1.rxd = v;
    endtask

    // Expected record {error, byte} from the frame's own contents
    function automatic logic [8:0] model(input logic [7:0] b, input bit pen,
                                         input bit pb, input bit stop);
        logic err;
        err = !stop || (pen && (((^b) ^ pb) != 1'b0));
        return {err, b};
    endfunction

    task automatic send_frame(input int ln, input logic [7:0] b,
                              input bit pen, input bit pb,
                              input bit stop, input int spike);
        set_line(ln, 1'b0);
        clks(BIT);
        for (int i = 0; i < 8; i++) begin
            set_line(ln, b[i]);
            if (i == spike) begin
                clks(32);
                set_line(ln, ~b[i]);
                clks(4);
                set_line(ln, b[i]);
                clks(28);
            end else begin
                clks(BIT);
            end
        end
        if (pen) begin
            set_line(ln, pb);
            clks(BIT);
        end
        set_line(ln, stop);
        clks(BIT);
    endtask

    task automatic send_exp(input int ln, input logic [7:0] b,
                            input bit pb, input bit stop, input int spike);
        bit pen;
        pen = (ln == 1);
        if (ln == 0) exp0.push_back(model(b, pen, pb, stop));
        else         exp1.push_back(model(b, pen, pb, stop));
        send_frame(ln, b, pen, pb, stop, spike);
    endtask

    task automatic check_q(input string tag);
        chk({tag, "_count0"}, 32'(obs0.size()), 32'(exp0.size()));
        chk({tag, "_count1"}, 32'(obs1.size()), 32'(exp1.size()));
        for (int i = 0; i < exp0.size() && i < obs0.size(); i++)
            chk({tag, "_frame0"}, 32'(obs0[i]), 32'(exp0[i]));
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++)
            chk({tag, "_frame1"}, 32'(obs1[i]), 32'(exp1[i]));
        obs0.delete();
        obs1.delete();
        exp0.delete();
        exp1.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data0"}, 32'(if0.rx_data), 32'h0);
        chk({tag, "_done0"}, 32'(if0.rx_done), 32'h0);
        chk({tag, "_err0"},  32'(if0.rx_error), 32'h0);
        chk({tag, "_busy0"}, 32'(if0.rx_busy), 32'h0);
        chk({tag, "_busy1"}, 32'(if1.rx_busy), 32'h0);
    endtask

    initial begin
        int unsigned st;
        int unsigned lat;
        logic [7:0] b;
        int ln;
        bit pb;
        bit stop;
        int spike;
        int gap;

        if0.rxd = 1'b1;
        if1.rxd = 1'b1;
        rstn = 1'b0;
        clks(3);
        check_reset_outputs("reset");
        rstn = 1'b1;
        clks(10);

        // Plain frame, latency window, then a glitch inside bit 3
        st = cyc;
        send_exp(0, 8'hA5, 1'b0, 1'b1, -1);
        clks(20);
        lat = done_cyc0 - st;
        chk("t1_latency_ok", 32'(lat >= 616 && lat <= 622), 32'h1);
        send_exp(0, 8'hA5, 1'b0, 1'b1, 3);
        clks(20);
        check_q("t1");

        // Short low pulse is a false start
        set_line(0, 1'b0);
        clks(4);
        chk("t2_busy_rise", 32'(if0.rx_busy), 32'h1);
        clks(16);
        set_line(0, 1'b1);
        clks(10);
        chk("t2_busy_hold", 32'(if0.rx_busy), 32'h1);
        clks(30);
        chk("t2_busy_fall", 32'(if0.rx_busy), 32'h0);
        clks(100);
        check_q("t2");

        // Bad stop bit followed by a held break, then recovery
        send_exp(0, 8'h3C, 1'b0, 1'b0, -1);
        clks(2000);
        check_q("t3_break");
        set_line(0, 1'b1);
        clks(BIT);
        send_exp(0, 8'h11, 1'b0, 1'b1, -1);
        clks(20);
        check_q("t3_recover");

        // Even parity good and bad
        send_exp(1, 8'h07, 1'b1, 1'b1, -1);
        clks(20);
        send_exp(1, 8'h07, 1'b0, 1'b1, -1);
        clks(20);
        check_q("t4");

        // Back-to-back frames with no idle gap
        send_exp(0, 8'h00, 1'b0, 1'b1, -1);
        send_exp(0, 8'hFF, 1'b0, 1'b1, -1);
        clks(20);
        check_q("t5");

        // Reset in the middle of data bit 4
        b = 8'h96;
        set_line(0, 1'b0);
        clks(BIT);
        for (int i = 0; i < 4; i++) begin
            set_line(0, b[i]);
            clks(BIT);
        end
        set_line(0, b[4]);
        clks(32);
        rstn = 1'b0;
        #1;
        check_reset_outputs("t6_abort");
        clks(10);
        set_line(0, 1'b1);
        rstn = 1'b1;
        clks(20);
        send_exp(0, 8'h5A, 1'b0, 1'b1, -1);
        clks(20);
        check_q("t6");

        // Randomized frames on both receivers
        for (int n = 0; n < 24; n++) begin
            ln = int'($urandom_range(0, 1));
            b = 8'($urandom);
            pb = 1'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            spike = int'($urandom_range(0, 9));
            send_exp(ln, b, pb, stop, spike);
            set_line(ln, 1'b1);
            gap = stop ? int'($urandom_range(0, 40))
                       : int'($urandom_range(8, 40));
            if (gap > 0) clks(gap);
        end
        clks(100);
        check_q("rand");

        chk("strobe_rules", 32'(viol0 + viol1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
